// File: rtl/mips32_mem_arbiter_if.sv
// Request/acknowledge bundle between the three memory requesters, the arbiter and the memory.
// The arbiter takes the slave view; requesters and memory (or a bench) take the master view.
interface mips32_mem_arbiter_if #(
  parameter int unsigned AW = 10
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [31:0]   if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_ack;
  logic [31:0]   dm_rdata;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_ack;
  logic [31:0]   ld_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic          busy;
  logic [1:0]    grant_id;

  modport master (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_ack, ld_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, grant_id
  );

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_ack, ld_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, grant_id
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Serialises instruction fetch, data load/store and loader/debug accesses onto one unified
// word memory: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP, one access at a time.
module mips32_mem_arbiter #(
  parameter int unsigned AW       = 10,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic                      clk1,
  input  logic                      reset,
  input  logic                      halted,
  mips32_mem_arbiter_if.slave       bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  localparam logic [1:0] GntIf   = 2'd0;
  localparam logic [1:0] GntDm   = 2'd1;
  localparam logic [1:0] GntLd   = 2'd2;
  localparam logic [1:0] GntNone = 2'd3;

  localparam int unsigned SW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] MaxWait = SW'(MAX_WAIT);
  localparam logic [2:0] LatLast = 3'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [2:0]    lat_q, lat_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= GntNone;
      starve_q <= '0;
      lat_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
      lat_q    <= lat_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    starve_d = starve_q;
    lat_d    = lat_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        grant_d = GntNone;
        if (halted) begin
          // Loader mode: fetch and data requests are ignored and the starve count is frozen.
          if (bus.ld_req) begin
            grant_d = GntLd;
            addr_d  = bus.ld_addr;
            we_d    = bus.ld_we;
            wdata_d = bus.ld_wdata;
          end
        end else if (bus.dm_req && !(bus.if_req && (starve_q == MaxWait))) begin
          grant_d  = GntDm;
          addr_d   = bus.dm_addr;
          we_d     = bus.dm_we;
          wdata_d  = bus.dm_wdata;
          // IF lost here, so the count is below MaxWait whenever if_req is high.
          starve_d = bus.if_req ? starve_q + SW'(1) : '0;
        end else if (bus.if_req) begin
          grant_d  = GntIf;
          addr_d   = bus.if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
        if (grant_d != GntNone) state_d = StAccess;
      end
      StAccess: begin
        lat_d   = LatLast;
        state_d = StWait;
      end
      StWait: begin
        if (lat_q == 3'd0) begin
          rdata_d = bus.mem_rdata;
          state_d = StResp;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      StResp: begin
        grant_d = GntNone;
        state_d = StIdle;
      end
    endcase
  end

  logic resp;
  assign resp = (state_q == StResp);

  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.grant_id  = grant_q;
    bus.mem_en    = (state_q == StAccess);
    bus.mem_we    = bus.mem_en & we_q;
    bus.mem_addr  = bus.mem_en ? addr_q : '0;
    bus.mem_wdata = bus.mem_en ? wdata_q : '0;
    bus.if_ack    = resp && (grant_q == GntIf);
    bus.dm_ack    = resp && (grant_q == GntDm);
    bus.ld_ack    = resp && (grant_q == GntLd);
    bus.if_rdata  = (bus.if_ack && !we_q) ? rdata_q : '0;
    bus.dm_rdata  = (bus.dm_ack && !we_q) ? rdata_q : '0;
    bus.ld_rdata  = (bus.ld_ack && !we_q) ? rdata_q : '0;
  end

endmodule
